// File: rtl/io_panel_if.sv
// CPU-side register window of the board I/O panel: 3-bit select, one-cycle
// write strobe, write data and registered read data.
interface io_panel_if #(
    parameter int WORD_SIZE = 16
);
    logic [2:0]           addr;
    logic                 wr;
    logic [WORD_SIZE-1:0] data_in;
    logic [WORD_SIZE-1:0] data_out;

    modport master (output addr, output wr, output data_in, input data_out);
    modport slave  (input addr, input wr, input data_in, output data_out);
endinterface

// File: rtl/io_panel.sv
// Memory-mapped board I/O: debounced buttons with sticky press flags,
// multiplexed seven-segment scan with per-digit blanking, and an LED register.
module io_panel #(
    parameter int WORD_SIZE      = 16,
    parameter int N_BTN          = 4,
    parameter int N_LED          = 4,
    parameter int N_DIG          = 4,
    parameter int SCAN_DIV       = 4096,
    parameter int DEB_DIV        = 65536,
    parameter int DEB_COUNT      = 4,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             reset,
    io_panel_if.slave        bus,
    input  logic [N_BTN-1:0] bt,
    output logic [N_LED-1:0] led,
    output logic [7:0]       seg,
    output logic [N_DIG-1:0] dig
);
    localparam int DISP_W = 4 * N_DIG;
    localparam int IDX_W  = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int DEB_W  = $clog2(DEB_DIV);
    localparam int CNT_W  = $clog2(DEB_COUNT + 1);
    localparam logic [N_BTN-1:0] BT_IDLE = (BTN_ACTIVE_LOW != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

    typedef enum logic [2:0] {
        A_DISP = 3'd0,
        A_DP   = 3'd1,
        A_LED  = 3'd2,
        A_CTRL = 3'd3,
        A_BTN  = 3'd4,
        A_EVT  = 3'd5
    } reg_addr_e;

    // Segment pattern {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  4'hF: hex7 = 7'h71;
        endcase
    endfunction

    logic [DISP_W-1:0]    disp_q, disp_d;
    logic [N_DIG-1:0]     dp_q, dp_d;
    logic [N_LED-1:0]     led_q, led_d;
    logic [N_DIG:0]       ctrl_q, ctrl_d;
    logic [N_BTN-1:0]     btn_q, btn_d;
    logic [N_BTN-1:0]     evt_q, evt_d;
    logic [N_BTN-1:0]     bt_meta_q, bt_sync_q;
    logic [CNT_W-1:0]     deb_cnt_q [N_BTN];
    logic [CNT_W-1:0]     deb_cnt_d [N_BTN];
    logic [DEB_W-1:0]     deb_div_q, deb_div_d;
    logic [SCAN_W-1:0]    scan_div_q, scan_div_d;
    logic [IDX_W-1:0]     scan_idx_q, scan_idx_d;
    logic [7:0]           seg_q, seg_d;
    logic [N_DIG-1:0]     dig_q, dig_d;
    logic [WORD_SIZE-1:0] data_out_q, data_out_d;

    logic             deb_tick, scan_wrap;
    logic [N_BTN-1:0] sample, evt_clr;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        disp_d = disp_q;
        dp_d   = dp_q;
        led_d  = led_q;
        ctrl_d = ctrl_q;
        if (bus.wr) begin
            case (bus.addr)
                A_DISP:  disp_d = bus.data_in[DISP_W-1:0];
                A_DP:    dp_d   = bus.data_in[N_DIG-1:0];
                A_LED:   led_d  = bus.data_in[N_LED-1:0];
                A_CTRL:  ctrl_d = bus.data_in[N_DIG:0];
                default: ;
            endcase
        end
    end

    // Debounce: a level flips only after DEB_COUNT consecutive differing ticks.
    always_comb begin
        deb_tick  = (deb_div_q == DEB_W'(DEB_DIV - 1));
        deb_div_d = deb_tick ? '0 : deb_div_q + 1'b1;
        sample    = bt_sync_q ^ BT_IDLE;
        btn_d     = btn_q;
        for (int i = 0; i < N_BTN; i++) begin
            deb_cnt_d[i] = deb_cnt_q[i];
            if (deb_tick) begin
                if (sample[i] == btn_q[i]) begin
                    deb_cnt_d[i] = '0;
                end else if (deb_cnt_q[i] == CNT_W'(DEB_COUNT - 1)) begin
                    btn_d[i]     = ~btn_q[i];
                    deb_cnt_d[i] = '0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
        evt_clr = (bus.wr && bus.addr == A_EVT) ? bus.data_in[N_BTN-1:0] : '0;
        // A press landing in the same cycle as its clear must not be lost.
        evt_d   = (evt_q & ~evt_clr) | (btn_d & ~btn_q);
    end

    always_comb begin
        scan_wrap  = (scan_div_q == SCAN_W'(SCAN_DIV - 1));
        scan_div_d = scan_wrap ? '0 : scan_div_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (scan_wrap) scan_idx_d = (scan_idx_q == IDX_W'(N_DIG - 1)) ? '0 : scan_idx_q + 1'b1;
        dig_d = '1;
        seg_d = 8'hFF;
        if (ctrl_q[0]) begin
            for (int i = 0; i < N_DIG; i++) begin
                if (scan_idx_q == IDX_W'(i) && !ctrl_q[i+1]) begin
                    dig_d[i] = 1'b0;
                    seg_d    = ~{dp_q[i], hex7(disp_q[4*i +: 4])};
                end
            end
        end
    end

    always_comb begin
        data_out_d = '0;
        case (bus.addr)
            A_DISP:  data_out_d[DISP_W-1:0] = disp_q;
            A_DP:    data_out_d[N_DIG-1:0]  = dp_q;
            A_LED:   data_out_d[N_LED-1:0]  = led_q;
            A_CTRL:  data_out_d[N_DIG:0]    = ctrl_q;
            A_BTN:   data_out_d[N_BTN-1:0]  = btn_q;
            A_EVT:   data_out_d[N_BTN-1:0]  = evt_q;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_q     <= '0;
            dp_q       <= '0;
            led_q      <= '0;
            ctrl_q     <= {{N_DIG{1'b0}}, 1'b1};
            btn_q      <= '0;
            evt_q      <= '0;
            bt_meta_q  <= BT_IDLE;
            bt_sync_q  <= BT_IDLE;
            // NOTE: the per-button counters are flops, not RAM, so each entry is reset.
            for (int i = 0; i < N_BTN; i++) deb_cnt_q[i] <= '0;
            deb_div_q  <= '0;
            scan_div_q <= '0;
            scan_idx_q <= '0;
            seg_q      <= 8'hFF;
            dig_q      <= '1;
            data_out_q <= '0;
        end else begin
            disp_q     <= disp_d;
            dp_q       <= dp_d;
            led_q      <= led_d;
            ctrl_q     <= ctrl_d;
            btn_q      <= btn_d;
            evt_q      <= evt_d;
            bt_meta_q  <= bt;
            bt_sync_q  <= bt_meta_q;
            for (int i = 0; i < N_BTN; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            deb_div_q  <= deb_div_d;
            scan_div_q <= scan_div_d;
            scan_idx_q <= scan_idx_d;
            seg_q      <= seg_d;
            dig_q      <= dig_d;
            data_out_q <= data_out_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign led          = ~led_q;
    assign seg          = seg_q;
    assign dig          = dig_q;
endmodule

// File: tb/tb_io_panel.sv
// Directed bench for io_panel: a 4-digit fast-scan instance and a 1-digit,
// single-sample-debounce instance share one clock and reset.
module tb_io_panel;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge reset)
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    io_panel_if #(.WORD_SIZE(16)) bus0 ();
    io_panel_if #(.WORD_SIZE(16)) bus1 ();
    logic [3:0] bt0, led0, dig0;
    logic [7:0] seg0;
    logic [3:0] bt1, led1;
    logic [0:0] dig1;
    logic [7:0] seg1;

    io_panel #(.N_DIG(4), .SCAN_DIV(4), .DEB_DIV(2), .DEB_COUNT(4)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .bt(bt0), .led(led0), .seg(seg0), .dig(dig0));
    io_panel #(.N_DIG(1), .SCAN_DIV(2), .DEB_DIV(2), .DEB_COUNT(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .bt(bt1), .led(led1), .seg(seg1), .dig(dig1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input int u, input logic [2:0] a, input logic [15:0] d);
        if (u == 0) begin bus0.addr = a; bus0.data_in = d; bus0.wr = 1'b1; end
        else        begin bus1.addr = a; bus1.data_in = d; bus1.wr = 1'b1; end
        tick();
        bus0.wr = 1'b0;
        bus1.wr = 1'b0;
    endtask

    task automatic bus_rd(input int u, input logic [2:0] a, output logic [15:0] d);
        if (u == 0) bus0.addr = a;
        else        bus1.addr = a;
        tick();
        d = (u == 0) ? bus0.data_out : bus1.data_out;
    endtask

    task automatic align_even();
        while (cyc % 2 != 0) tick();
    endtask

    // Lands on the first sample where digit 0 takes over from digit 3.
    task automatic sync_digit0();
        int k;
        k = 0;
        while (dig0 != 4'h7 && k < 64) begin tick(); k++; end
        while (dig0 == 4'h7 && k < 64) begin tick(); k++; end
        if (k >= 64) check("scan_sync_timeout", 32'(k), 32'd0);
    endtask

    logic [15:0] rd;
    logic [3:0]  exp_dig [4];
    logic [7:0]  exp_seg [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bt0 = 4'hF; bt1 = 4'hF;
        bus0.addr = '0; bus0.wr = 1'b0; bus0.data_in = '0;
        bus1.addr = '0; bus1.wr = 1'b0; bus1.data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", bus0.data_out, 16'h0000);
        check("rst_led", led0, 4'hF);
        check("rst_seg", seg0, 8'hFF);
        check("rst_dig", dig0, 4'hF);
        check("rst_dig_1dig", dig1, 1'b1);
        reset = 1'b1;

        bus_rd(0, 3'd3, rd); check("ctrl_reset", rd, 16'h0001);
        bus_rd(0, 3'd0, rd); check("disp_reset", rd, 16'h0000);
        bus_rd(0, 3'd5, rd); check("evt_reset", rd, 16'h0000);

        // LED register and unmapped addresses
        bus_wr(0, 3'd2, 16'h0009);
        check("led_pins", led0, 4'b0110);
        bus_rd(0, 3'd2, rd); check("led_read", rd, 16'h0009);
        bus_wr(0, 3'd6, 16'hFFFF);
        bus_rd(0, 3'd6, rd); check("addr6_zero", rd, 16'h0000);
        bus_rd(0, 3'd7, rd); check("addr7_zero", rd, 16'h0000);
        bus0.addr = 3'd2; bus0.data_in = 16'h0003; bus0.wr = 1'b1;
        tick();
        bus0.wr = 1'b0;
        check("rd_during_wr_old", bus0.data_out, 16'h0009);
        check("led_pins_new", led0, 4'hC);

        // Display scan, 4 clocks per digit
        bus_wr(0, 3'd0, 16'h12AF);
        exp_dig = '{4'hE, 4'hD, 4'hB, 4'h7};
        exp_seg = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
        sync_digit0();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("scan_dig%0d", i), dig0, exp_dig[i]);
            check($sformatf("scan_seg%0d", i), seg0, exp_seg[i]);
            tick(3);
            check($sformatf("scan_hold%0d", i), dig0, exp_dig[i]);
            tick(1);
        end

        // Blank digit 1, decimal point on digit 0
        bus_wr(0, 3'd3, 16'h0005);
        bus_wr(0, 3'd1, 16'h0001);
        exp_dig = '{4'hE, 4'hF, 4'hB, 4'h7};
        exp_seg = '{8'h0E, 8'hFF, 8'hA4, 8'hF9};
        sync_digit0();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("blank_dig%0d", i), dig0, exp_dig[i]);
            check($sformatf("blank_seg%0d", i), seg0, exp_seg[i]);
            tick(4);
        end

        bus_wr(0, 3'd3, 16'h0000);
        tick(1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("disabled_dig%0d", i), dig0, 4'hF);
            check($sformatf("disabled_seg%0d", i), seg0, 8'hFF);
            tick(3);
        end
        bus_wr(0, 3'd3, 16'h0001);
        bus_wr(0, 3'd1, 16'h0000);

        // Three-tick glitch on button 2 must be ignored
        align_even();
        bt0[2] = 1'b0;
        tick(6);
        bt0[2] = 1'b1;
        tick(8);
        bus_rd(0, 3'd4, rd); check("glitch_btn", rd, 16'h0000);
        bus_rd(0, 3'd5, rd); check("glitch_evt", rd, 16'h0000);

        // Stable press: level rises on the 4th sampling tick, edge p+10,
        // coinciding with a W1C write to EVT.
        align_even();
        bt0[2] = 1'b0;
        tick(8);
        bus0.addr = 3'd4;
        tick(1);
        check("btn_before_rise", bus0.data_out, 16'h0000);
        bus0.addr = 3'd5; bus0.data_in = 16'h0004; bus0.wr = 1'b1;
        tick(1);
        bus0.wr = 1'b0;
        check("evt_old_on_race", bus0.data_out, 16'h0000);
        tick(1);
        check("evt_set_wins", bus0.data_out, 16'h0004);
        bus0.addr = 3'd4;
        tick(1);
        check("btn_pressed", bus0.data_out, 16'h0004);
        bus_wr(0, 3'd5, 16'h0004);
        bus_rd(0, 3'd5, rd); check("evt_cleared", rd, 16'h0000);
        bus_rd(0, 3'd4, rd); check("btn_held", rd, 16'h0004);
        bt0[2] = 1'b1;
        tick(12);
        bus_rd(0, 3'd4, rd); check("btn_released", rd, 16'h0000);
        bus_rd(0, 3'd5, rd); check("evt_no_release_set", rd, 16'h0000);

        // Single-digit instance: digit stays on across scan wraps
        bus_wr(1, 3'd0, 16'h0005);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("one_dig_on%0d", i), dig1, 1'b0);
            check($sformatf("one_dig_seg%0d", i), seg1, 8'h92);
            tick(1);
        end

        // DEB_COUNT=1: one differing tick changes the level
        align_even();
        bt1[0] = 1'b0;
        bus1.addr = 3'd4;
        tick(4);
        check("d1_btn_pre", bus1.data_out, 16'h0000);
        tick(1);
        check("d1_btn_rise", bus1.data_out, 16'h0001);
        bus_rd(1, 3'd5, rd); check("d1_evt_set", rd, 16'h0001);
        bus_wr(1, 3'd5, 16'h0001);
        bus_rd(1, 3'd5, rd); check("d1_evt_clear", rd, 16'h0000);
        align_even();
        bt1[0] = 1'b1;
        bus1.addr = 3'd4;
        tick(2);
        bt1[0] = 1'b0;
        tick(3);
        check("d1_btn_fall", bus1.data_out, 16'h0000);
        tick(2);
        check("d1_btn_rerise", bus1.data_out, 16'h0001);
        bus_rd(1, 3'd5, rd); check("d1_evt_rerise", rd, 16'h0001);

        // Reset in the middle of operation
        bus_rd(0, 3'd2, rd); check("led_before_reset", rd, 16'h0003);
        reset = 1'b0;
        #2;
        check("midrst_data_out", bus0.data_out, 16'h0000);
        check("midrst_led", led0, 4'hF);
        check("midrst_seg", seg0, 8'hFF);
        check("midrst_dig", dig0, 4'hF);
        check("midrst_seg_1dig", seg1, 8'hFF);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        bus0.addr = 3'd3;
        tick(2);
        check("ctrl_after_reset", bus0.data_out, 16'h0001);
        bus_rd(0, 3'd2, rd); check("led_reg_after_reset", rd, 16'h0000);
        bus_rd(1, 3'd5, rd); check("evt_after_reset", rd, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
